// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the device over the shared PS2_CLK/PS2_DAT pair.
// Both lines are driven open-drain through output enables (1 = pull low).
// busy also gates the receive path so it ignores the host's own frame.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned RTS_CYCLES     = 250,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] cmd_byte,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   // One shared counter covers the inhibit, request-to-send and timeout intervals.
   localparam int unsigned MAX_A  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W  = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_NACK    = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StShift,
      StAck,
      StWaitIdle,
      StFail
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       data_q;
   logic             parity_q;

   logic clk_meta, clk_sync, clk_prev;
   logic dat_meta, dat_sync;
   logic clk_fe;
   logic timed_out;

   // Two-flop synchronizers for both pads, plus a delayed clock copy for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_meta <= 1'b0;
         clk_sync <= 1'b0;
         clk_prev <= 1'b0;
         dat_meta <= 1'b0;
         dat_sync <= 1'b0;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_dat_in;
         dat_sync <= dat_meta;
      end
   end

   // Device clock falling edge, and expiry of the inter-edge timeout.
   always_comb begin
      clk_fe    = clk_prev & ~clk_sync;
      timed_out = (cnt == TIMEOUT_LAST);
   end

   // Transaction FSM; every output is registered so the pad enables never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         cnt        <= '0;
         bit_idx    <= '0;
         data_q     <= '0;
         parity_q   <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         unique case (state)
            StIdle: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (send) begin
                  data_q     <= cmd_byte;
                  parity_q   <= ~^cmd_byte;
                  err_code   <= ERR_NONE;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  state      <= StInhibit;
               end
            end

            StInhibit: begin
               if (cnt == INHIBIT_LAST) begin
                  cnt        <= '0;
                  ps2_dat_oe <= 1'b1;   // start bit
                  state      <= StRts;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StRts: begin
               if (cnt == RTS_LAST) begin
                  cnt        <= '0;
                  bit_idx    <= '0;
                  ps2_clk_oe <= 1'b0;   // hand the clock over to the device
                  state      <= StShift;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StShift: begin
               if (clk_fe) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx < 4'd8) begin
                     ps2_dat_oe <= ~data_q[bit_idx[2:0]];
                  end else if (bit_idx == 4'd8) begin
                     ps2_dat_oe <= ~parity_q;
                  end else begin
                     ps2_dat_oe <= 1'b0;   // stop bit: release the line
                     state      <= StAck;
                  end
               end else if (timed_out) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  err_code   <= ERR_TIMEOUT;
                  error      <= 1'b1;
                  busy       <= 1'b0;
                  state      <= StFail;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StAck: begin
               if (clk_fe) begin
                  cnt <= '0;
                  if (!dat_sync) begin
                     state <= StWaitIdle;
                  end else begin
                     err_code <= ERR_NACK;
                     error    <= 1'b1;
                     busy     <= 1'b0;
                     state    <= StFail;
                  end
               end else if (timed_out) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  err_code   <= ERR_TIMEOUT;
                  error      <= 1'b1;
                  busy       <= 1'b0;
                  state      <= StFail;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StWaitIdle: begin
               if (clk_sync && dat_sync) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (clk_fe) begin
                  cnt <= '0;
               end else if (timed_out) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  err_code   <= ERR_TIMEOUT;
                  error      <= 1'b1;
                  busy       <= 1'b0;
                  state      <= StFail;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StFail: begin
               // error was raised on entry; this cycle is the pulse itself
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               state      <= StIdle;
            end

            default: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               busy       <= 1'b0;
               state      <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND pads.
module tb_ps2_host_tx;

   localparam int unsigned TO_CYC = 2000;
   localparam int          H      = 20;   // device clock half period in clk cycles

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       send = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;
   logic [1:0] err_code;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;

   int vectors = 0;
   int miscompares = 0;

   int n_done = 0;
   int n_err = 0;
   logic overlap_seen = 1'b0;
   logic busy_at_pulse = 1'b0;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(6000),
      .RTS_CYCLES    (250),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .send      (send),
      .cmd_byte  (cmd_byte),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_code  (err_code)
   );

   // Pulse monitor
   always @(negedge clk) begin
      if (reset) begin
         if (done) n_done <= n_done + 1;
         if (error) n_err <= n_err + 1;
         if (done && error) overlap_seen <= 1'b1;
         if ((done || error) && busy) busy_at_pulse <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue_send(input logic [7:0] b);
      @(negedge clk);
      cmd_byte = b;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
   endtask

   // Device: waits for request-to-send, then clocks n_edges falling edges and
   // records the data line just before each following rising edge.
   task automatic dev_frame(input int n_edges, input logic ack_bit,
                            output logic [9:0] bits, output logic started);
      bits = '0;
      started = 1'b0;
      for (int i = 0; i < 20000 && !started; i++) begin
         @(negedge clk);
         if (!ps2_clk_oe && ps2_dat_oe) started = 1'b1;
      end
      if (!started) return;
      repeat (H) @(negedge clk);
      for (int k = 0; k < n_edges && k < 10; k++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         bits[k] = ps2_dat_in;
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      if (n_edges >= 11) begin
         dev_dat = ack_bit;
         repeat (H / 2) @(negedge clk);
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
         dev_dat = 1'b1;
      end
   endtask

   initial begin
      logic [9:0] bits;
      logic       started;
      int         cnt_inh, cnt_rts, d0, e0, lat;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // 0xED with ACK: inhibit and RTS lengths, line bits, done
      d0 = n_done; e0 = n_err;
      issue_send(8'hED);
      check("ed_busy", 32'(busy), 32'd1);
      cnt_inh = 0;
      for (int i = 0; i < 10000 && ps2_clk_oe && !ps2_dat_oe; i++) begin
         cnt_inh++;
         @(negedge clk);
      end
      cnt_rts = 0;
      for (int i = 0; i < 1000 && ps2_clk_oe && ps2_dat_oe; i++) begin
         cnt_rts++;
         @(negedge clk);
      end
      check("ed_inhibit_len", 32'(cnt_inh), 32'd6000);
      check("ed_rts_len", 32'(cnt_rts), 32'd250);
      dev_frame(11, 1'b0, bits, started);
      check("ed_started", 32'(started), 32'd1);
      check("ed_bits", 32'(bits), 32'h3ED);
      repeat (50) @(negedge clk);
      check("ed_done_cnt", 32'(n_done - d0), 32'd1);
      check("ed_err_cnt", 32'(n_err - e0), 32'd0);
      check("ed_err_code", 32'(err_code), 32'd0);
      check("ed_busy_end", 32'(busy), 32'd0);
      check("ed_oe_end", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

      // 0x00 then 0xF4 back to back
      d0 = n_done;
      issue_send(8'h00);
      dev_frame(11, 1'b0, bits, started);
      check("b00_bits", 32'(bits), 32'h300);
      repeat (50) @(negedge clk);
      check("b00_done_cnt", 32'(n_done - d0), 32'd1);
      d0 = n_done;
      issue_send(8'hF4);
      dev_frame(11, 1'b0, bits, started);
      check("bf4_bits", 32'(bits), 32'h2F4);
      repeat (50) @(negedge clk);
      check("bf4_done_cnt", 32'(n_done - d0), 32'd1);

      // 0xFF with NACK
      d0 = n_done; e0 = n_err;
      issue_send(8'hFF);
      dev_frame(11, 1'b1, bits, started);
      check("ff_bits", 32'(bits), 32'h3FF);
      repeat (50) @(negedge clk);
      check("ff_err_cnt", 32'(n_err - e0), 32'd1);
      check("ff_done_cnt", 32'(n_done - d0), 32'd0);
      check("ff_err_code", 32'(err_code), 32'd2);
      check("ff_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("ff_busy", 32'(busy), 32'd0);

      // Device stops after fe 4: timeout
      d0 = n_done; e0 = n_err;
      issue_send(8'h5A);
      dev_frame(4, 1'b0, bits, started);
      check("to_busy_mid", 32'(busy), 32'd1);
      lat = 0;
      for (int i = 0; i < 3000 && n_err == e0; i++) begin
         lat++;
         @(negedge clk);
      end
      check("to_err_cnt", 32'(n_err - e0), 32'd1);
      check("to_latency_ok", 32'(lat >= 1900 && lat <= 2050), 32'd1);
      check("to_err_code", 32'(err_code), 32'd1);
      check("to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("to_busy", 32'(busy), 32'd0);
      check("to_done_cnt", 32'(n_done - d0), 32'd0);

      // Asynchronous reset during SHIFT after fe 6
      issue_send(8'h00);
      dev_frame(6, 1'b0, bits, started);
      check("ar_pre_busy", 32'(busy), 32'd1);
      check("ar_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("ar_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      d0 = n_done;
      issue_send(8'hA5);
      dev_frame(11, 1'b0, bits, started);
      check("ar_next_bits", 32'(bits), 32'h3A5);
      repeat (50) @(negedge clk);
      check("ar_next_done", 32'(n_done - d0), 32'd1);

      // send while busy is ignored
      d0 = n_done;
      issue_send(8'h12);
      repeat (100) @(negedge clk);
      cmd_byte = 8'h34;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      dev_frame(11, 1'b0, bits, started);
      check("ign_bits", 32'(bits), 32'h312);
      repeat (50) @(negedge clk);
      check("ign_done_cnt", 32'(n_done - d0), 32'd1);
      check("ign_busy", 32'(busy), 32'd0);

      check("pulse_overlap", 32'(overlap_seen), 32'd0);
      check("busy_during_pulse", 32'(busy_at_pulse), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as 0xED (set LEDs) and 0xFF (reset), on the same PS2_CLK/PS2_DAT pair that the keyboard receive path listens on. It drives both lines open-drain through output-enable signals; the top level ties each pad to 0 when its OE is 1 and to high-Z otherwise. It reports completion, ACK/NACK and timeout, and raises a gating signal so the receive path ignores the host's own frame.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles PS2 clock is held low before request-to-send (120 us at 50 MHz)
RTS_CYCLES, 250, clk cycles with clock and data both held low before the clock is released
TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between successive device clock falling edges (20 ms)

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous active-low reset (KEY[0])
send  in  1  start request; sampled only in IDLE
cmd_byte  in  8  byte to transmit; latched when send is accepted
ps2_clk_in  in  1  PS2_CLK pad value (asynchronous)
ps2_dat_in  in  1  PS2_DAT pad value (asynchronous)
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_dat_oe  out  1  1 = pull PS2_DAT low
busy  out  1  transaction in progress; also gates the receive driver
done  out  1  one-cycle pulse: byte sent and ACKed
error  out  1  one-cycle pulse: transaction failed
err_code  out  2  01 = timeout, 10 = NACK; holds until next accepted send

Behaviour:
- Reset (async, low): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, err_code=00, all counters and synchronizers cleared. Lines release immediately, including mid-frame.
- Input synchronization: ps2_clk_in and ps2_dat_in each pass through 2 flops. A falling edge (fe) is prev_sync=1 and sync=0. This gives 2–3 cycles of latency from the pad.
- IDLE: both OE=0, busy=0. If send=1, latch cmd_byte, compute parity = ~^cmd_byte (odd parity), clear err_code, go to INHIBIT. busy=1 from the next cycle.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: clk_oe=1, dat_oe=1 (start bit 0) for RTS_CYCLES cycles, then SHIFT with clk_oe=0, dat_oe=1, bit index=0, timeout counter=0.
- SHIFT: the device generates the clock. Each fe advances the index and presents the next bit; the driven value is dat_oe = ~bit.
  - fe 1..8 present d0..d7, LSB first.
  - fe 9 presents parity.
  - fe 10 presents the stop bit (dat_oe=0, line released), then go to ACK.
- ACK: on fe 11, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: err_code=10, go to FAIL.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse done for 1 cycle and return to IDLE.
- FAIL: pulse error for 1 cycle, both OE=0, return to IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE the counter increments each cycle and clears on every fe. Reaching TIMEOUT_CYCLES releases both lines, sets err_code=01 and goes to FAIL.
- send while busy is ignored; no queuing. cmd_byte changes after acceptance have no effect.
- done and error never assert in the same cycle. busy deasserts in the same cycle the done or error pulse is high.
- Device clock edges seen in IDLE, INHIBIT or RTS are ignored.
- OE outputs are registered, so the pads are glitch-free.

Test Plan:
- send with cmd_byte=0xED; device model clocks 11 edges and ACKs low → clk_oe high for 6000 cycles, then clk_oe+dat_oe high for 250 cycles. Line bits after fe1..fe10 are 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once, err_code=00, busy falls.
- cmd_byte=0x00 then 0xF4 back-to-back (second send issued after done) → parity bits 1 and 0 respectively; both transactions complete with done.
- Device drives data 1 on ACK clock for cmd_byte=0xFF → error pulse, err_code=10, both OE=0, no done.
- Device stops clocking after fe 4 → after 1000000 idle cycles: error pulse, err_code=01, lines released, busy=0.
- Assert reset during SHIFT after fe 6 → ps2_clk_oe=0 and ps2_dat_oe=0 in the same cycle with no clk edge, busy=0. A following send runs a normal transaction.
- send pulsed while busy with a different cmd_byte → ignored; the transmitted byte is the first one; exactly one done.
